// File: rtl/ahb_latency_ram_pkg.sv
// ahb_latency_ram_pkg
//   Shared types for the latency-injecting AHB-Lite RAM responder:
//   the configuration record (cvw_t), the HTRANS encodings, the responder
//   state enum and a helper that sizes the wait counter.
package ahb_latency_ram_pkg;

    // Subset of the core configuration record used by this block.
    typedef struct packed {
        int unsigned AHBW;         // bus data width in bits
        int unsigned RAM_LATENCY;  // wait states per NONSEQ beat
        bit          BURST_EN;     // SEQ beats complete with zero waits
        int unsigned PA_BITS;      // physical address width
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{AHBW: 64, RAM_LATENCY: 2, BURST_EN: 1'b1, PA_BITS: 32};

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } ahbram_state_t;

    // Counter must hold RAM_LATENCY; a zero-latency build still needs one bit.
    function automatic int cnt_width(input int unsigned lat);
        return (lat == 0) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/ram1p1rwbe.sv
// ram1p1rwbe
//   Byte-enabled synchronous RAM. Reads are registered: rdata_o changes only
//   on a cycle with re_i, so the last read word is held between reads. A
//   write and a read issue can land on the same cycle (write data phase of
//   one beat overlapping the pipelined address of the next), so the write
//   and read addresses are separate. Same-word collisions return the old
//   contents; the caller merges in the write bytes.
//   Ports:
//     clk_i, rst_i  clock / async active-high reset (read register only)
//     re_i, raddr_i read issue and word address
//     we_i, waddr_i write enable and word address
//     be_i, wdata_i byte strobes and write data
//     rdata_o       registered read data
module ram1p1rwbe #(
    parameter int WIDTH = 64,
    parameter int ABITS = 13
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               re_i,
    input  logic [ABITS-1:0]   raddr_i,
    input  logic               we_i,
    input  logic [ABITS-1:0]   waddr_i,
    input  logic [WIDTH/8-1:0] be_i,
    input  logic [WIDTH-1:0]   wdata_i,
    output logic [WIDTH-1:0]   rdata_o
);

    logic [WIDTH-1:0] mem [2**ABITS];
    logic [WIDTH-1:0] rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < WIDTH/8; b++) begin
            if (we_i && be_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_latency_ram.sv
// ahb_latency_ram
//   AHB-Lite responder RAM that inserts P.RAM_LATENCY wait states on every
//   NONSEQ beat (and on SEQ beats unless P.BURST_EN) to exercise the
//   manager's wait-state and burst handling. Always answers OKAY.
//   PRELOAD marks builds whose array image (ram.mem) is supplied by the
//   platform memory-load flow; the RAM itself has no initial contents.
//   Ports:
//     clk, reset       clock / async active-high reset
//     HSELRam          decoder select
//     HADDR, HWRITE, HTRANS, HSIZE, HBURST  address phase
//     HREADY           muxed global ready
//     HWDATA, HWSTRB   data phase write data / byte strobes
//     HREADYRam        this responder's ready
//     HRESPRam         response (always OKAY)
//     HREADRam         read data
module ahb_latency_ram
    import ahb_latency_ram_pkg::*;
#(
    parameter cvw_t        P       = CVW_DEFAULT,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter logic [63:0] RANGE   = 64'h0000_FFFF,
    parameter bit          PRELOAD = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   HSELRam,
    input  logic [P.PA_BITS-1:0]   HADDR,
    input  logic                   HWRITE,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HSIZE,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [P.AHBW-1:0]      HWDATA,
    input  logic [P.AHBW/8-1:0]    HWSTRB,
    output logic                   HREADYRam,
    output logic                   HRESPRam,
    output logic [P.AHBW-1:0]      HREADRam
);

    localparam int AW   = P.AHBW;
    localparam int BW   = AW / 8;
    localparam int PAW  = P.PA_BITS;
    localparam int OFFB = $clog2(BW);
    localparam int IDXW = $clog2(RANGE + 64'd1) - OFFB;
    localparam int CW   = cnt_width(P.RAM_LATENCY);

    ahbram_state_t   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0] addr_q, addr_d;
    logic            write_q, write_d;
    logic            fwd_q, fwd_d;
    logic [AW-1:0]   fwd_data_q, fwd_data_d;
    logic [BW-1:0]   fwd_strb_q, fwd_strb_d;

    logic            accept;
    logic [CW-1:0]   wc;
    logic [PAW-1:0]  offs;
    logic [IDXW-1:0] haddr_idx;
    logic            data_phase;
    logic            ram_re, ram_we;
    logic [IDXW-1:0] ram_raddr;
    logic [AW-1:0]   ram_rdata;
    logic            unused_ok;

    // Region offset truncated to the array index; out-of-range addresses wrap.
    assign offs      = HADDR - BASE[PAW-1:0];
    assign haddr_idx = offs[OFFB +: IDXW];

    assign accept     = HSELRam & HREADY & HTRANS[1];
    assign wc         = (P.BURST_EN && HTRANS == HTRANS_SEQ) ? '0 : CW'(P.RAM_LATENCY);
    assign data_phase = (state_q == ST_DATA);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        fwd_strb_d = fwd_strb_q;
        ram_re     = 1'b0;
        ram_raddr  = addr_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                // Last wait cycle: launch the array read so data is there in DATA.
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DATA;
                    if (!write_q) begin
                        ram_re = 1'b1;
                        fwd_d  = 1'b0;
                    end
                end
            end
            default: begin  // IDLE or DATA: bus may present a new address
                if (accept) begin
                    addr_d  = haddr_idx;
                    write_d = HWRITE;
                    cnt_d   = wc;
                    state_d = (wc == '0) ? ST_DATA : ST_WAIT;
                    if (wc == '0 && !HWRITE) begin
                        ram_re     = 1'b1;
                        ram_raddr  = haddr_idx;
                        // Read of the word being written this cycle: the array
                        // returns stale data, so keep the write bytes to overlay.
                        fwd_d      = data_phase && write_q && (haddr_idx == addr_q);
                        fwd_data_d = HWDATA;
                        fwd_strb_d = HWSTRB;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            fwd_strb_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            fwd_strb_q <= fwd_strb_d;
        end
    end

    assign ram_we = data_phase & write_q;

    ram1p1rwbe #(.WIDTH(AW), .ABITS(IDXW)) u_ram (
        .clk_i   (clk),
        .rst_i   (reset),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .we_i    (ram_we),
        .waddr_i (addr_q),
        .be_i    (HWSTRB),
        .wdata_i (HWDATA),
        .rdata_o (ram_rdata)
    );

    // Forward flag and bytes change only with a read issue, so the merged
    // output holds its value between reads just like the array register.
    always_comb begin
        HREADRam = ram_rdata;
        for (int b = 0; b < BW; b++) begin
            if (fwd_q && fwd_strb_q[b]) HREADRam[b*8 +: 8] = fwd_data_q[b*8 +: 8];
        end
    end

    assign HREADYRam = (state_q != ST_WAIT);
    assign HRESPRam  = 1'b0;

    // Size/burst never affect timing; lanes come from HWSTRB only.
    assign unused_ok = ^{HSIZE, HBURST, offs, PRELOAD};

endmodule

// File: tb/tb_ahb_latency_ram.sv
// Self-checking bench: three responders (latency 2 with/without burst
// shortcut, latency 0) on shared bus wires; 'act' picks which one is selected.
module tb_ahb_latency_ram;
    import ahb_latency_ram_pkg::*;

    localparam cvw_t C0 = '{AHBW: 64, RAM_LATENCY: 2, BURST_EN: 1'b1, PA_BITS: 32};
    localparam cvw_t C1 = '{AHBW: 64, RAM_LATENCY: 2, BURST_EN: 1'b0, PA_BITS: 32};
    localparam cvw_t C2 = '{AHBW: 64, RAM_LATENCY: 0, BURST_EN: 1'b1, PA_BITS: 32};

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [63:0] hwdata;
    logic [7:0]  hwstrb;
    int          act;

    logic        r0, r1, r2, p0, p1, p2;
    logic [63:0] d0, d1, d2;
    logic        rdy, hresp;
    logic [63:0] hread;

    assign rdy   = (act == 0) ? r0 : (act == 1) ? r1 : r2;
    assign hresp = (act == 0) ? p0 : (act == 1) ? p1 : p2;
    assign hread = (act == 0) ? d0 : (act == 1) ? d1 : d2;

    always #5 clk = ~clk;

    ahb_latency_ram #(.P(C0)) dut0 (
        .clk(clk), .reset(reset), .HSELRam(hsel && act == 0), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HREADY(r0), .HWDATA(hwdata),
        .HWSTRB(hwstrb), .HREADYRam(r0), .HRESPRam(p0), .HREADRam(d0));
    ahb_latency_ram #(.P(C1)) dut1 (
        .clk(clk), .reset(reset), .HSELRam(hsel && act == 1), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HREADY(r1), .HWDATA(hwdata),
        .HWSTRB(hwstrb), .HREADYRam(r1), .HRESPRam(p1), .HREADRam(d1));
    ahb_latency_ram #(.P(C2)) dut2 (
        .clk(clk), .reset(reset), .HSELRam(hsel && act == 2), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HREADY(r2), .HWDATA(hwdata),
        .HWSTRB(hwstrb), .HREADYRam(r2), .HRESPRam(p2), .HREADRam(d2));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One non-pipelined transfer; returns read data and number of wait cycles.
    task automatic single(input bit wr, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s, output logic [63:0] rd, output int waits);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr;
        tick();
        hsel = 1'b0; htrans = 2'b00; hwdata = d; hwstrb = s;
        waits = 0;
        while (!rdy && waits < 20) begin
            waits++;
            tick();
        end
        if (waits >= 20) chk("single_timeout", 64'(waits), 64'd0);
        rd = hread;
        chk("single_hresp", 64'(hresp), 64'd0);
        tick();
        hwdata = '0; hwstrb = '0;
    endtask

    int          b_waits[4];
    logic [63:0] b_dat[4];

    // INCR4 read: returns cycles from first address phase through last data cycle.
    task automatic burst4(input logic [31:0] base, output int cyc);
        int cur, datab, done;
        bit r;
        hsel = 1'b1; hwrite = 1'b0; htrans = 2'b10; haddr = base; hburst = 3'b011;
        cur = 0; datab = -1; done = 0; cyc = 0;
        for (int k = 0; k < 4; k++) begin b_waits[k] = 0; b_dat[k] = '0; end
        while (done < 4 && cyc <= 40) begin
            r = rdy;
            cyc++;
            if (datab >= 0) begin
                if (!r) b_waits[datab]++;
                else begin b_dat[datab] = hread; done++; end
            end
            if (done < 4) begin
                tick();
                if (r) begin
                    if (cur < 4) begin
                        datab = cur;
                        cur++;
                        if (cur < 4) begin htrans = 2'b11; haddr = base + 32'(8 * cur); end
                        else begin htrans = 2'b00; hsel = 1'b0; end
                    end else datab = -1;
                end
            end
        end
        if (done != 4) chk("burst_timeout", 64'(done), 64'd4);
        tick();
        hburst = 3'b000;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        logic [63:0] exp;
    } vec_t;

    vec_t        vt[13];
    logic [63:0] rd, held;
    int          w, cyc;
    logic [63:0] bexp[4];

    initial begin
        vt[0]  = '{1'b1, 32'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h0};
        vt[1]  = '{1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'h1122334455667788};
        vt[2]  = '{1'b1, 32'h8000_0010, 64'h000000000000AAAA, 8'h03, 64'h0};
        vt[3]  = '{1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'h112233445566AAAA};
        vt[4]  = '{1'b1, 32'h8000_0030, 64'h5, 8'hFF, 64'h0};
        vt[5]  = '{1'b0, 32'h8000_0030, 64'h0, 8'h00, 64'h5};
        vt[6]  = '{1'b1, 32'h8000_0018, 64'h0, 8'hFF, 64'h0};
        vt[7]  = '{1'b1, 32'h8000_0018, 64'hA5A5A5A5A5A5A5A5, 8'h81, 64'h0};
        vt[8]  = '{1'b0, 32'h8000_0018, 64'h0, 8'h00, 64'hA5000000000000A5};
        vt[9]  = '{1'b1, 32'h8001_0008, 64'h0BADF00DCAFEF00D, 8'hFF, 64'h0};  // wraps to 0x08
        vt[10] = '{1'b0, 32'h8000_0008, 64'h0, 8'h00, 64'h0BADF00DCAFEF00D};
        vt[11] = '{1'b1, 32'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, 64'h0};
        vt[12] = '{1'b0, 32'h8000_0000, 64'h0, 8'h00, 64'h0123456789ABCDEF};
        bexp[0] = 64'h0123456789ABCDEF; bexp[1] = 64'h0BADF00DCAFEF00D;
        bexp[2] = 64'h112233445566AAAA; bexp[3] = 64'hA5000000000000A5;

        reset = 1'b1; act = 0; hsel = 1'b0; haddr = '0; hwrite = 1'b0; htrans = 2'b00;
        hsize = 3'b011; hburst = 3'b000; hwdata = '0; hwstrb = '0;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            act = k;
            #1;
            chk("reset_hready", 64'(rdy), 64'd1);
            chk("reset_hresp", 64'(hresp), 64'd0);
            chk("reset_hread", hread, 64'h0);
        end
        act = 0;
        reset = 1'b0;
        tick();

        // Directed single transfers on the latency-2 responder.
        for (int i = 0; i < 13; i++) begin
            single(vt[i].wr, vt[i].a, vt[i].d, vt[i].s, rd, w);
            chk($sformatf("vec%0d_waits", i), 64'(w), 64'd2);
            if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
        end

        // Burst with zero-wait SEQ beats.
        burst4(32'h8000_0000, cyc);
        chk("burst_en_cycles", 64'(cyc), 64'd7);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("burst_en_waits%0d", k), 64'(b_waits[k]), (k == 0) ? 64'd2 : 64'd0);
            chk($sformatf("burst_en_data%0d", k), b_dat[k], bexp[k]);
        end

        // BUSY and deselected cycles: nothing may move.
        held = hread;
        hsel = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h8000_0010;
        hwdata = '1; hwstrb = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin hsel = 1'b0; htrans = 2'b10; end
            tick();
            chk($sformatf("idle%0d_hready", k), 64'(rdy), 64'd1);
            chk($sformatf("idle%0d_hresp", k), 64'(hresp), 64'd0);
            chk($sformatf("idle%0d_hread", k), hread, held);
        end
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = '0; hwstrb = '0;
        tick();
        single(1'b0, 32'h8000_0010, 64'h0, 8'h00, rd, w);
        chk("idle_no_write", rd, 64'h112233445566AAAA);

        // Reset during the wait of a write: ready returns at once, write dropped.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h8000_0030; hwrite = 1'b1;
        tick();
        hsel = 1'b0; htrans = 2'b00; hwdata = 64'h77; hwstrb = 8'hFF;
        chk("rst_in_wait", 64'(rdy), 64'd0);
        reset = 1'b1;
        #1;
        chk("rst_async_hready", 64'(rdy), 64'd1);
        tick();
        reset = 1'b0; hwdata = '0; hwstrb = '0;
        tick();
        single(1'b0, 32'h8000_0030, 64'h0, 8'h00, rd, w);
        chk("rst_write_dropped", rd, 64'h5);
        chk("rst_read_waits", 64'(w), 64'd2);

        // Same burst without the SEQ shortcut.
        act = 1;
        for (int k = 0; k < 4; k++) single(1'b1, 32'h8000_0000 + 32'(8 * k), bexp[k], 8'hFF, rd, w);
        burst4(32'h8000_0000, cyc);
        chk("burst_off_cycles", 64'(cyc), 64'd13);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("burst_off_waits%0d", k), 64'(b_waits[k]), 64'd2);
            chk($sformatf("burst_off_data%0d", k), b_dat[k], bexp[k]);
        end

        // Zero latency: pipelined read of the word written in the same cycle.
        act = 2;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h8000_0020; hwrite = 1'b1;
        tick();
        chk("fwd_w1_hready", 64'(rdy), 64'd1);
        hwdata = 64'h00000000DEADBEEF; hwstrb = 8'hFF; hwrite = 1'b0;
        tick();
        chk("fwd_r1_hready", 64'(rdy), 64'd1);
        chk("fwd_r1_data", hread, 64'h00000000DEADBEEF);
        hwrite = 1'b1; hwdata = '0; hwstrb = '0;
        tick();
        chk("fwd_w2_hready", 64'(rdy), 64'd1);
        hwdata = 64'h00005A5A00000000; hwstrb = 8'h30; hwrite = 1'b0;
        tick();
        chk("fwd_r2_hready", 64'(rdy), 64'd1);
        chk("fwd_r2_merge", hread, 64'h00005A5ADEADBEEF);
        hsel = 1'b0; htrans = 2'b00; hwdata = '0; hwstrb = '0;
        tick();
        single(1'b0, 32'h8000_0020, 64'h0, 8'h00, rd, w);
        chk("lat0_read_data", rd, 64'h00005A5ADEADBEEF);
        chk("lat0_read_waits", 64'(w), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
